// File: rtl/aes_pkg.sv
// Shared AES datapath types and widths for the round-key consumer stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aes_pkg;

    localparam int AES_BLOCK_W      = 128;
    localparam int SRAM_ADDR_W      = 16;
    localparam int ROUND_W          = 4;
    localparam int AES128_MAX_ROUND = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } keyAddState_t;

    // Word address of a round key; 16-bit arithmetic, wraps mod 2^16.
    function automatic logic [SRAM_ADDR_W-1:0] roundKeyAddr(
        input logic [SRAM_ADDR_W-1:0] base,
        input logic [SRAM_ADDR_W-1:0] stride,
        input logic [ROUND_W-1:0]     roundIdx
    );
        return base + SRAM_ADDR_W'(roundIdx) * stride;
    endfunction

endpackage

// File: rtl/round_key_fetch.sv
// Round-key SRAM reader: drives read strobe/address and flags the beat on which the key is sampled.
// Latency: key presented READ_LATENCY cycles after start (strobe and address held throughout).
// Backpressure: none; cancel drops the strobe on the next edge and abandons the read.
//
// Ports:
//   clk, rst       clock, async active-high reset
//   start          pulse from the handshake FSM: begin a read of round roundIdx
//   cancel         requester withdrew; abandon the read in flight
//   roundIdx       round key index, used only on start
//   sramReadValue  SRAM read data
//   sramRead       SRAM read strobe (registered)
//   sramAddr       SRAM word address (registered, held after the read)
//   keyValid       high in the cycle whose closing edge samples the key
//   keyData        key word to sample when keyValid is high
module round_key_fetch
    import aes_pkg::*;
#(
    parameter logic [SRAM_ADDR_W-1:0] KEY_BASE_ADDR = 16'h0000,
    parameter logic [SRAM_ADDR_W-1:0] KEY_STRIDE    = 16'd1,
    parameter int                     READ_LATENCY  = 1   // legal range 1..4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   cancel,
    input  logic [ROUND_W-1:0]     roundIdx,
    input  logic [AES_BLOCK_W-1:0] sramReadValue,
    output logic                   sramRead,
    output logic [SRAM_ADDR_W-1:0] sramAddr,
    output logic                   keyValid,
    output logic [AES_BLOCK_W-1:0] keyData
);

    localparam logic [2:0] CNT_LAST = 3'(READ_LATENCY - 1);

    logic [2:0] cnt;

    // The strobe itself marks an active read, so no separate busy flag is kept.
    assign keyValid = sramRead && (cnt == CNT_LAST);
    assign keyData  = sramReadValue;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sramRead <= 1'b0;
            sramAddr <= '0;
            cnt      <= '0;
        end else if (start) begin
            sramRead <= 1'b1;
            sramAddr <= roundKeyAddr(KEY_BASE_ADDR, KEY_STRIDE, roundIdx);
            cnt      <= '0;
        end else if (sramRead) begin
            if (cancel || keyValid) begin
                sramRead <= 1'b0;
                cnt      <= '0;
            end else begin
                cnt      <= cnt + 3'd1;
            end
        end
    end

endmodule

// File: rtl/round_key_add.sv
// AES AddRoundKey consumer: fetches round key roundNum from key SRAM and XORs it into the state.
// Latency: done READ_LATENCY+1 edges after the request is raised; 1 edge for keyError or cache hit.
// Backpressure: level handshake; done held until enable drops, enable low mid-fetch aborts.
//
// Ports:
//   clk, rst       clock, async active-high reset
//   enable         level request, held until done is seen
//   roundNum       round key index, sampled on acceptance
//   stateIn        cipher state, sampled on acceptance
//   sramReadValue  key SRAM read data
//   sramRead       key SRAM read strobe
//   sramAddr       key SRAM word address
//   stateOut       stateIn ^ round key, valid while done
//   done           completion, held until enable is low
//   keyError       roundNum > MAX_ROUND (stateOut then equals stateIn)
//
// Build option ROUND_KEY_CACHE_EN: one-entry {valid, round, key} cache so a repeated round
// skips the SRAM read; without it every legal request reads the SRAM.
module round_key_add
    import aes_pkg::*;
#(
    parameter logic [SRAM_ADDR_W-1:0] KEY_BASE_ADDR = 16'h0000,
    parameter logic [SRAM_ADDR_W-1:0] KEY_STRIDE    = 16'd1,
    parameter int                     READ_LATENCY  = 1,
    parameter int                     MAX_ROUND     = AES128_MAX_ROUND
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [ROUND_W-1:0]     roundNum,
    input  logic [AES_BLOCK_W-1:0] stateIn,
    input  logic [AES_BLOCK_W-1:0] sramReadValue,
    output logic                   sramRead,
    output logic [SRAM_ADDR_W-1:0] sramAddr,
    output logic [AES_BLOCK_W-1:0] stateOut,
    output logic                   done,
    output logic                   keyError
);

    keyAddState_t           fsmState;
    logic [AES_BLOCK_W-1:0] latchedState;
    logic                   roundLegal;
    logic                   cacheHit;
    logic                   fetchStart;
    logic                   fetchCancel;
    logic                   keyValid;
    logic [AES_BLOCK_W-1:0] keyData;

    assign roundLegal  = int'(roundNum) <= MAX_ROUND;
    assign fetchStart  = (fsmState == IDLE) && enable && roundLegal && !cacheHit;
    assign fetchCancel = (fsmState == FETCH) && !enable;

`ifdef ROUND_KEY_CACHE_EN
    logic                   cacheValid;
    logic [ROUND_W-1:0]     cacheRound;
    logic [AES_BLOCK_W-1:0] cacheKey;
    logic [ROUND_W-1:0]     latchedRound;

    assign cacheHit = cacheValid && (cacheRound == roundNum);

    // Only a fetch that actually completes refreshes the entry; aborts leave it as is.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cacheValid   <= 1'b0;
            cacheRound   <= '0;
            cacheKey     <= '0;
            latchedRound <= '0;
        end else begin
            if (fsmState == IDLE && enable) begin
                latchedRound <= roundNum;
            end
            if (fsmState == FETCH && enable && keyValid) begin
                cacheValid <= 1'b1;
                cacheRound <= latchedRound;
                cacheKey   <= keyData;
            end
        end
    end
`else
    assign cacheHit = 1'b0;
`endif

    round_key_fetch #(
        .KEY_BASE_ADDR (KEY_BASE_ADDR),
        .KEY_STRIDE    (KEY_STRIDE),
        .READ_LATENCY  (READ_LATENCY)
    ) u_fetch (
        .clk           (clk),
        .rst           (rst),
        .start         (fetchStart),
        .cancel        (fetchCancel),
        .roundIdx      (roundNum),
        .sramReadValue (sramReadValue),
        .sramRead      (sramRead),
        .sramAddr      (sramAddr),
        .keyValid      (keyValid),
        .keyData       (keyData)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsmState     <= IDLE;
            latchedState <= '0;
            stateOut     <= '0;
            done         <= 1'b0;
            keyError     <= 1'b0;
        end else begin
            case (fsmState)
                IDLE: begin
                    if (enable) begin
                        latchedState <= stateIn;
                        if (!roundLegal) begin
                            // Illegal round: pass the state through untouched, no SRAM access.
                            stateOut <= stateIn;
                            keyError <= 1'b1;
                            done     <= 1'b1;
                            fsmState <= DONE;
`ifdef ROUND_KEY_CACHE_EN
                        end else if (cacheHit) begin
                            stateOut <= stateIn ^ cacheKey;
                            done     <= 1'b1;
                            fsmState <= DONE;
`endif
                        end else begin
                            fsmState <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    // Abort takes priority over a key arriving on the same edge.
                    if (!enable) begin
                        fsmState <= IDLE;
                    end else if (keyValid) begin
                        stateOut <= latchedState ^ keyData;
                        done     <= 1'b1;
                        fsmState <= DONE;
                    end
                end
                DONE: begin
                    // Holding enable high here never re-triggers; it must drop first.
                    if (!enable) begin
                        done     <= 1'b0;
                        keyError <= 1'b0;
                        fsmState <= IDLE;
                    end
                end
                default: fsmState <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_round_key_add.sv
module tb_round_key_add;

    localparam int          RL_A     = 1;
    localparam int          RL_B     = 3;
    localparam logic [15:0] BASE_B   = 16'h0010;
    localparam logic [15:0] STRIDE_B = 16'd2;
    localparam logic [127:0] GARBAGE = 128'hdead_beef_0bad_f00d_dead_beef_0bad_f00d;
`ifdef ROUND_KEY_CACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         enable;
    logic [3:0]   roundNum;
    logic [127:0] stateIn;

    logic         sramReadA, sramReadB;
    logic [15:0]  sramAddrA, sramAddrB;
    logic [127:0] sramReadValueA, sramReadValueB;
    logic [127:0] stateOutA, stateOutB;
    logic         doneA, doneB, keyErrorA, keyErrorB;

    logic [127:0] memA [0:63];
    logic [127:0] memB [0:63];
    int           heldA = 0, heldB = 0;

    int total = 0;
    int bad   = 0;

    // reference cache model (only consulted when the cache is built in)
    bit         cvA = 0, cvB = 0;
    logic [3:0] crA = '0, crB = '0;

    round_key_add dutA (
        .clk(clk), .rst(rst), .enable(enable), .roundNum(roundNum), .stateIn(stateIn),
        .sramReadValue(sramReadValueA), .sramRead(sramReadA), .sramAddr(sramAddrA),
        .stateOut(stateOutA), .done(doneA), .keyError(keyErrorA)
    );

    round_key_add #(
        .KEY_BASE_ADDR(BASE_B), .KEY_STRIDE(STRIDE_B), .READ_LATENCY(RL_B), .MAX_ROUND(10)
    ) dutB (
        .clk(clk), .rst(rst), .enable(enable), .roundNum(roundNum), .stateIn(stateIn),
        .sramReadValue(sramReadValueB), .sramRead(sramReadB), .sramAddr(sramAddrB),
        .stateOut(stateOutB), .done(doneB), .keyError(keyErrorB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: data is only correct once the read has been held long enough.
    always @(posedge clk) begin
        heldA <= sramReadA ? heldA + 1 : 0;
        heldB <= sramReadB ? heldB + 1 : 0;
    end
    assign sramReadValueA = (sramReadA && heldA >= RL_A - 1) ? memA[sramAddrA[5:0]] : GARBAGE;
    assign sramReadValueB = (sramReadB && heldB >= RL_B - 1) ? memB[sramAddrB[5:0]] : GARBAGE;

    task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] addrB(input logic [3:0] r);
        return BASE_B + 16'(r) * STRIDE_B;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called right after a negedge; returns right after a negedge.
    task automatic runReq(input logic [3:0] r, input logic [127:0] s, input bit dropAfter);
        bit legal, hitA, hitB;
        int expEdgeA, expEdgeB, expReadsA, expReadsB;
        int edgeA, edgeB, readsA, readsB, addrBadA, addrBadB;
        logic [127:0] expOutA, expOutB;
        logic [15:0]  tmp;
        legal     = (r <= 4'd10);
        hitA      = CACHE_ON && legal && cvA && (crA == r);
        hitB      = CACHE_ON && legal && cvB && (crB == r);
        expEdgeA  = (!legal || hitA) ? 1 : RL_A + 1;
        expEdgeB  = (!legal || hitB) ? 1 : RL_B + 1;
        expReadsA = (legal && !hitA) ? RL_A : 0;
        expReadsB = (legal && !hitB) ? RL_B : 0;
        tmp       = addrB(r);
        expOutA   = legal ? (s ^ memA[r]) : s;
        expOutB   = legal ? (s ^ memB[tmp[5:0]]) : s;
        edgeA = 0; edgeB = 0; readsA = 0; readsB = 0; addrBadA = 0; addrBadB = 0;

        roundNum = r;
        stateIn  = s;
        enable   = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (doneA && edgeA == 0) edgeA = n;
            if (doneB && edgeB == 0) edgeB = n;
            if (sramReadA) begin
                readsA++;
                if (sramAddrA !== 16'(r)) addrBadA++;
            end
            if (sramReadB) begin
                readsB++;
                if (sramAddrB !== addrB(r)) addrBadB++;
            end
            // inputs after acceptance must be ignored
            if (n == 1) begin
                roundNum = 4'($urandom);
                stateIn  = rand128();
            end
        end
        checkVal("doneEdgeA", 128'(edgeA), 128'(expEdgeA));
        checkVal("doneEdgeB", 128'(edgeB), 128'(expEdgeB));
        checkVal("stateOutA", stateOutA, expOutA);
        checkVal("stateOutB", stateOutB, expOutB);
        checkVal("keyErrorA", 128'(keyErrorA), 128'(!legal));
        checkVal("keyErrorB", 128'(keyErrorB), 128'(!legal));
        checkVal("readsA", 128'(readsA), 128'(expReadsA));
        checkVal("readsB", 128'(readsB), 128'(expReadsB));
        checkVal("addrA", 128'(addrBadA), 128'd0);
        checkVal("addrB", 128'(addrBadB), 128'd0);
        if (legal && !hitA) begin cvA = 1; crA = r; end
        if (legal && !hitB) begin cvB = 1; crB = r; end
        if (dropAfter) begin
            enable = 1'b0;
            @(negedge clk);
            checkVal("doneDropA", 128'(doneA), 128'd0);
            checkVal("doneDropB", 128'(doneB), 128'd0);
            checkVal("keyErrDropB", 128'(keyErrorB), 128'd0);
        end
    endtask

    // Abort dutB in its 2nd fetch cycle; dutA (latency 1) completes before the drop.
    task automatic abortReq(input logic [3:0] r, input logic [127:0] s);
        logic [127:0] prevB;
        prevB    = stateOutB;
        roundNum = r;
        stateIn  = s;
        enable   = 1'b1;
        @(negedge clk);
        checkVal("abortReadB1", 128'(sramReadB), 128'd1);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        checkVal("abortDoneB", 128'(doneB), 128'd0);
        checkVal("abortReadB", 128'(sramReadB), 128'd0);
        checkVal("abortOutB", stateOutB, prevB);
        checkVal("abortOutA", stateOutA, s ^ memA[r]);
        cvA = 1; crA = r;
        @(negedge clk);
        checkVal("abortDoneB2", 128'(doneB), 128'd0);
    endtask

    initial begin
        logic [3:0] r;
        enable   = 1'b0;
        roundNum = '0;
        stateIn  = '0;
        rst      = 1'b0;
        for (int i = 0; i < 64; i++) begin
            memA[i] = rand128();
            memB[i] = rand128();
        end
        memA[0] = 128'h000102030405060708090a0b0c0d0e0f;

        #2 rst = 1'b1;
        #1;
        checkVal("rstReadA", 128'(sramReadA), 128'd0);
        checkVal("rstAddrA", 128'(sramAddrA), 128'd0);
        checkVal("rstOutA", stateOutA, 128'd0);
        checkVal("rstDoneA", 128'(doneA), 128'd0);
        checkVal("rstErrA", 128'(keyErrorA), 128'd0);
        checkVal("rstReadB", 128'(sramReadB), 128'd0);
        checkVal("rstDoneB", 128'(doneB), 128'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // FIPS-197 C.1 round 0
        runReq(4'd0, 128'h00112233445566778899aabbccddeeff, 1'b1);
        checkVal("fipsOut", stateOutA, 128'h00102030405060708090a0b0c0d0e0f0);
        // base/stride/latency on dutB: addr 0x12, 3 read cycles, done at edge 4
        runReq(4'd1, rand128(), 1'b1);
        // illegal round
        runReq(4'd11, rand128(), 1'b1);
        // repeated round (cache hit when built in), then a new round
        runReq(4'd3, rand128(), 1'b1);
        runReq(4'd3, rand128(), 1'b1);
        runReq(4'd4, rand128(), 1'b1);
        for (int k = 0; k < 8; k++) begin
            r = 4'($urandom_range(0, 12));
            runReq(r, rand128(), 1'b1);
        end

        r = (cvB && crB == 4'd5) ? 4'd6 : 4'd5;
        abortReq(r, rand128());
        runReq(r, rand128(), 1'b1);

        // reset while in DONE with enable still high
        runReq(4'd12, rand128(), 1'b0);
        #2 rst = 1'b1;
        #1;
        checkVal("midRstDoneA", 128'(doneA), 128'd0);
        checkVal("midRstDoneB", 128'(doneB), 128'd0);
        checkVal("midRstErrA", 128'(keyErrorA), 128'd0);
        checkVal("midRstOutA", stateOutA, 128'd0);
        checkVal("midRstOutB", stateOutB, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        cvA = 0; cvB = 0;
        runReq(4'd2, rand128(), 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
